// File: rtl/usb_tx_engine_if.sv
// Packet handoff bundle between the protocol FSM and the USB transmit engine.
interface usb_tx_engine_if #(
    parameter int MAX_BYTES = 64
);
    localparam int LW = $clog2(MAX_BYTES + 1);

    logic                   pkt_valid;
    logic                   pkt_ready;
    logic [3:0]             pkt_pid;
    logic [1:0]             pkt_crc_mode;
    logic [LW-1:0]          pkt_len;
    logic [8*MAX_BYTES-1:0] pkt_data;

    modport master (
        output pkt_valid, pkt_pid, pkt_crc_mode, pkt_len, pkt_data,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid, pkt_pid, pkt_crc_mode, pkt_len, pkt_data,
        output pkt_ready
    );
endinterface

// File: rtl/usb_tx_engine.sv
// USB full-speed transmit engine: SYNC/PID/payload/CRC serialiser with
// bit stuffing, NRZI encoding and EOP generation on the DP/DM pair.
module usb_tx_engine #(
    parameter int MAX_BYTES = 64,
    parameter int STUFF_LEN = 6,
    parameter int SYNC_BITS = 8
) (
    input  logic           clk,
    input  logic           rst_b,
    usb_tx_engine_if.slave pkt,
    output logic           dp_w,
    output logic           dm_w,
    output logic           tx_active,
    output logic           tx_done
);
    localparam int LW = $clog2(MAX_BYTES + 1);
    localparam int DW = 8 * MAX_BYTES;
    localparam int CW = $clog2(8 * MAX_BYTES + 17);
    localparam int OW = $clog2(STUFF_LEN + 1);

    localparam logic [1:0] M_TOK  = 2'b01;
    localparam logic [1:0] M_DATA = 2'b10;

    typedef enum logic [2:0] {
        IDLE, SYNC, PID, FIELD, CRC, EOP0, EOP1, EOPJ
    } state_t;

    // state_q/cnt_q name the source bit currently on the line
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, last_q, last_c;
    logic [OW-1:0] ones_q;
    logic [1:0]    mode_q, mode_c;
    logic          zlp_q;
    logic [7:0]    pid_q;
    logic [DW-1:0] data_q;
    logic [15:0]   crc_q, crc_upd;
    logic          dp_q, dm_q, act_q, done_q;
    logic [LW-1:0] len_c;
    logic          stuff, raw, fb5, fb16;

    always_comb begin
        len_c  = (pkt.pkt_len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : pkt.pkt_len;
        mode_c = (pkt.pkt_crc_mode == 2'b11) ? 2'b00 : pkt.pkt_crc_mode;
        last_c = (mode_c == M_TOK) ? CW'(10)
                                   : CW'({len_c, 3'b000}) - CW'(1);
    end

    always_comb begin
        stuff = (ones_q == OW'(STUFF_LEN)) &&
                (state_q inside {SYNC, PID, FIELD, CRC});
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        unique case (state_q)
            IDLE: state_d = IDLE;
            SYNC: if (cnt_q == CW'(SYNC_BITS - 1)) begin
                state_d = PID;
                cnt_d   = '0;
            end
            PID: if (cnt_q == CW'(7)) begin
                cnt_d = '0;
                if (mode_q == M_TOK)       state_d = FIELD;
                else if (mode_q == M_DATA) state_d = zlp_q ? CRC : FIELD;
                else                       state_d = EOP0;
            end
            FIELD: if (cnt_q == last_q) begin
                state_d = CRC;
                cnt_d   = '0;
            end
            CRC: if (cnt_q == ((mode_q == M_TOK) ? CW'(4) : CW'(15))) begin
                state_d = EOP0;
                cnt_d   = '0;
            end
            EOP0: state_d = EOP1;
            EOP1: state_d = EOPJ;
            EOPJ: state_d = IDLE;
        endcase
    end

    always_comb begin
        raw = 1'b0;
        unique case (state_d)
            SYNC:    raw = (cnt_d == CW'(SYNC_BITS - 1));
            PID:     raw = pid_q[0];
            FIELD:   raw = data_q[0];
            CRC:     raw = (mode_q == M_TOK) ? ~crc_q[4] : ~crc_q[15];
            default: raw = 1'b0;
        endcase
        fb5  = crc_q[4] ^ data_q[0];
        fb16 = crc_q[15] ^ data_q[0];
        if (mode_q == M_TOK)
            crc_upd = {11'd0, crc_q[3:0], 1'b0} ^ (fb5 ? 16'h0005 : 16'h0000);
        else
            crc_upd = {crc_q[14:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000);
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            ones_q  <= '0;
            mode_q  <= '0;
            zlp_q   <= 1'b0;
            pid_q   <= '0;
            data_q  <= '0;
            crc_q   <= '0;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                dp_q <= 1'b1;
                dm_q <= 1'b0;
                if (pkt.pkt_valid) begin
                    // first SYNC zero goes out with the accept edge
                    state_q <= SYNC;
                    cnt_q   <= '0;
                    ones_q  <= '0;
                    mode_q  <= mode_c;
                    zlp_q   <= (len_c == '0);
                    last_q  <= last_c;
                    pid_q   <= {~pkt.pkt_pid, pkt.pkt_pid};
                    data_q  <= pkt.pkt_data;
                    crc_q   <= (mode_c == M_TOK) ? 16'h001F : 16'hFFFF;
                    dp_q    <= 1'b0;
                    dm_q    <= 1'b1;
                    act_q   <= 1'b1;
                end
            end else if (stuff) begin
                dp_q   <= dm_q;
                dm_q   <= dp_q;
                ones_q <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                unique case (state_d)
                    SYNC, PID, FIELD, CRC: begin
                        if (raw) begin
                            ones_q <= ones_q + OW'(1);
                        end else begin
                            ones_q <= '0;
                            dp_q   <= dm_q;
                            dm_q   <= dp_q;
                        end
                        if (state_d == PID) pid_q <= {1'b0, pid_q[7:1]};
                        if (state_d == FIELD) begin
                            data_q <= data_q >> 1;
                            crc_q  <= crc_upd;
                        end
                        if (state_d == CRC) crc_q <= {crc_q[14:0], 1'b0};
                    end
                    EOP0, EOP1: begin
                        dp_q   <= 1'b0;
                        dm_q   <= 1'b0;
                        ones_q <= '0;
                    end
                    EOPJ: begin
                        dp_q <= 1'b1;
                        dm_q <= 1'b0;
                    end
                    IDLE: begin
                        act_q  <= 1'b0;
                        done_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign pkt.pkt_ready = (state_q == IDLE);
    assign dp_w          = dp_q;
    assign dm_w          = dm_q;
    assign tx_active     = act_q;
    assign tx_done       = done_q;
endmodule

// File: tb/tb_usb_tx_engine.sv
// Bench for usb_tx_engine: line decoder plus golden packet model,
// compared through an expected-result queue.
module tb_usb_tx_engine;
    localparam int MB = 64;
    localparam int LW = $clog2(MB + 1);
    localparam int DW = 8 * MB;

    logic clk = 1'b0;
    logic rst_b;
    logic dp_w, dm_w, tx_active, tx_done;

    always #5 clk = ~clk;

    usb_tx_engine_if #(.MAX_BYTES(MB)) pif ();

    usb_tx_engine #(
        .MAX_BYTES(MB),
        .STUFF_LEN(6),
        .SYNC_BITS(8)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .pkt      (pif),
        .dp_w     (dp_w),
        .dm_w     (dm_w),
        .tx_active(tx_active),
        .tx_done  (tx_done)
    );

    typedef struct {
        logic [1023:0] bits;
        int            nbits;
        int            stuffs;
        int            cycles;
        bit            eop_ok;
        bit            line_ok;
        int            start_cyc;
        int            done_cyc;
    } res_t;

    res_t       exp_q[$];
    res_t       res_q[$];
    logic [1:0] cap[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_total = 0;

    // NRZI-decode and de-stuff the captured symbols of one packet
    function automatic res_t decode();
        res_t       r;
        logic [1:0] prev;
        int         ones, n;
        bit         b;
        r.bits = '0;
        r.nbits = 0;
        r.stuffs = 0;
        r.line_ok = 1'b1;
        r.start_cyc = 0;
        r.done_cyc = 0;
        n = cap.size();
        r.cycles = n;
        r.eop_ok = (n >= 3) && cap[n-3] == 2'b00 && cap[n-2] == 2'b00
                   && cap[n-1] == 2'b10;
        prev = 2'b10;
        ones = 0;
        for (int i = 0; i < n - 3; i++) begin
            if (cap[i] == 2'b00 || cap[i] == 2'b11) r.line_ok = 1'b0;
            b = (cap[i] == prev);
            prev = cap[i];
            if (ones == 6) begin
                if (b) r.line_ok = 1'b0;
                r.stuffs++;
                ones = 0;
            end else begin
                if (r.nbits < 1024) r.bits[r.nbits] = b;
                r.nbits++;
                ones = b ? ones + 1 : 0;
            end
        end
        return r;
    endfunction

    function automatic res_t model(input logic [3:0] pid, input logic [1:0] mode,
                                   input int len, input logic [DW-1:0] data);
        res_t        e;
        logic [7:0]  p;
        logic [4:0]  c5;
        logic [15:0] c16;
        logic [1:0]  m;
        int          n, ones, st, l;
        bit          b, fb;
        e.bits = '0;
        n = 0;
        for (int i = 0; i < 7; i++) begin e.bits[n] = 1'b0; n++; end
        e.bits[n] = 1'b1; n++;
        p = {~pid, pid};
        for (int i = 0; i < 8; i++) begin e.bits[n] = p[i]; n++; end
        m = (mode == 2'b11) ? 2'b00 : mode;
        l = (len > MB) ? MB : len;
        if (m == 2'b01) begin
            c5 = 5'h1F;
            for (int i = 0; i < 11; i++) begin
                b = data[i];
                e.bits[n] = b; n++;
                fb = c5[4] ^ b;
                c5 = {c5[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
            end
            for (int i = 4; i >= 0; i--) begin e.bits[n] = ~c5[i]; n++; end
        end else if (m == 2'b10) begin
            c16 = 16'hFFFF;
            for (int i = 0; i < 8 * l; i++) begin
                b = data[i];
                e.bits[n] = b; n++;
                fb = c16[15] ^ b;
                c16 = {c16[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
            for (int i = 15; i >= 0; i--) begin e.bits[n] = ~c16[i]; n++; end
        end
        ones = 0;
        st = 0;
        for (int i = 0; i < n; i++) begin
            ones = e.bits[i] ? ones + 1 : 0;
            if (ones == 6) begin st++; ones = 0; end
        end
        e.nbits = n;
        e.stuffs = st;
        e.cycles = n + st + 3;
        e.eop_ok = 1'b1;
        e.line_ok = 1'b1;
        e.start_cyc = 0;
        e.done_cyc = 0;
        return e;
    endfunction

    initial begin : mon
        int start;
        res_t r;
        start = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_done) done_total++;
            if (rst_b) begin
                cap.delete();
            end else if (tx_active) begin
                if (cap.size() == 0) start = cyc;
                cap.push_back({dp_w, dm_w});
            end else if (tx_done) begin
                r = decode();
                r.start_cyc = start;
                r.done_cyc = cyc;
                res_q.push_back(r);
                cap.delete();
            end
        end
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_bits(input string tag, input logic [1023:0] obs,
                            input logic [1023:0] expv);
        int k;
        checks++;
        k = -1;
        for (int i = 1023; i >= 0; i--) if (obs[i] !== expv[i]) k = i;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: first differing bit %0d observed %0b expected %0b",
                   tag, k, obs[k], expv[k]);
        end
    endtask

    task automatic send(input logic [3:0] pid, input logic [1:0] mode,
                        input int len, input logic [DW-1:0] data);
        int n;
        n = 0;
        while (pif.pkt_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("send_ready_wait", longint'(n < 2000), 1);
        pif.pkt_valid = 1'b1;
        pif.pkt_pid = pid;
        pif.pkt_crc_mode = mode;
        pif.pkt_len = LW'(len);
        pif.pkt_data = data;
        exp_q.push_back(model(pid, mode, len, data));
        @(posedge clk); #1;
        pif.pkt_valid = 1'b0;
        pif.pkt_pid = ~pid;
        pif.pkt_crc_mode = ~mode;
        pif.pkt_data = ~data;
    endtask

    task automatic check_pkt(input string tag, output res_t r);
        res_t e;
        int n;
        n = 0;
        while (res_q.size() == 0 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_arrived"}, longint'(res_q.size() > 0), 1);
        r = '{default: 0};
        e = '{default: 0};
        if (res_q.size() > 0) r = res_q.pop_front();
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk_bits({tag, "_bits"}, r.bits, e.bits);
        chk({tag, "_nbits"}, r.nbits, e.nbits);
        chk({tag, "_stuffs"}, r.stuffs, e.stuffs);
        chk({tag, "_cycles"}, r.cycles, e.cycles);
        chk({tag, "_eop"}, longint'(r.eop_ok), 1);
        chk({tag, "_line"}, longint'(r.line_ok), 1);
    endtask

    initial begin : wdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        res_t r, a;
        int d0;
        logic [DW-1:0] rd;
        logic [15:0] ack_bits;
        rst_b = 1'b1;
        pif.pkt_valid = 1'b0;
        pif.pkt_pid = '0;
        pif.pkt_crc_mode = '0;
        pif.pkt_len = '0;
        pif.pkt_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dp", dp_w, 1);
        chk("rst_dm", dm_w, 0);
        chk("rst_active", tx_active, 0);
        chk("rst_done", tx_done, 0);
        rst_b = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", pif.pkt_ready, 1);

        d0 = done_total;
        send(4'h2, 2'b00, 0, '0);
        check_pkt("ack", r);
        ack_bits = r.bits[15:0];
        chk("ack_raw", ack_bits, 16'hD280);
        chk("ack_active_cycles", r.cycles, 19);
        chk("ack_no_stuff", r.stuffs, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ack_done_pulses", done_total - d0, 1);

        send(4'hD, 2'b01, 0, '0);
        check_pkt("setup", r);
        chk("setup_crc5_line", {r.bits[27], r.bits[28], r.bits[29],
                                r.bits[30], r.bits[31]}, 5'b01000);
        chk("setup_active_cycles", r.cycles, 35);

        send(4'h9, 2'b01, 0, DW'(11'h53A));
        check_pkt("in_token", r);

        send(4'h3, 2'b10, 0, '0);
        check_pkt("zlp", r);
        chk("zlp_crc16_zero", r.bits[31:16], 0);

        send(4'hB, 2'b10, 2, DW'(16'hFFFF));
        check_pkt("data1_ffff", r);

        rd = '0;
        for (int i = 0; i < DW / 32; i++) rd[32*i +: 32] = $urandom;
        send(4'h3, 2'b10, 5, rd);
        check_pkt("data0_rand", r);

        send(4'hA, 2'b11, 3, rd);
        check_pkt("mode3_as_pid", r);
        chk("mode3_active_cycles", r.cycles, 19);

        send(4'hC, 2'b10, 8, rd);
        repeat (40) @(posedge clk);
        #1;
        rst_b = 1'b1;
        #1;
        chk("abort_dp", dp_w, 1);
        chk("abort_dm", dm_w, 0);
        chk("abort_active", tx_active, 0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(posedge clk); #1;
        chk("abort_no_result", res_q.size(), 0);
        chk("abort_ready", pif.pkt_ready, 1);
        send(4'hB, 2'b10, 3, ~rd);
        check_pkt("post_abort", r);

        send(4'h3, 2'b10, 3, rd);
        pif.pkt_valid = 1'b1;
        pif.pkt_pid = 4'hB;
        pif.pkt_crc_mode = 2'b10;
        pif.pkt_len = LW'(1);
        pif.pkt_data = DW'(8'hC3);
        exp_q.push_back(model(4'hB, 2'b10, 1, DW'(8'hC3)));
        check_pkt("busy_first", a);
        @(posedge clk); #1;
        pif.pkt_valid = 1'b0;
        check_pkt("busy_second", r);
        chk("second_after_done", r.start_cyc, a.done_cyc + 1);

        for (int i = 0; i < DW / 32; i++) rd[32*i +: 32] = $urandom;
        send(4'h3, 2'b10, MB + 1, rd);
        check_pkt("len_clamp", r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
